// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART transmit path.
//   - uart_state_e : frame sequencer states (3-bit encoding)
//   - UART_IDLE_LEVEL / START_BIT / STOP_BIT : line levels used on TX_OUT
//   - cnt_width()  : width of a bit counter for a given data width, never
//                    narrower than one bit so a 1-bit data word still has
//                    a legal counter
//
// No ports; imported by the transmit frame sequencer.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;

    // $clog2(1) is 0, which would give a zero-width counter, so clamp to 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmit frame sequencer and serializer. Takes a parallel word from
// the data source and sends start bit, data bits LSB first, an optional
// parity bit and a stop bit on TX_OUT. The parity bit itself comes from an
// external parity calculator, which uses BUSY to freeze PAR_bit for the
// frame in flight.
//
// Parameters:
//   DATA_WIDTH  number of data bits per frame (>= 1)
//
// Ports:
//   CLK         clock
//   RST         synchronous, active-high reset
//   TICK        bit-period strobe; the sequencer only advances when high
//   DATA_VALID  upstream has a word on P_DATA
//   P_DATA      word to transmit, sampled on the accept edge
//   PAR_EN      1 = frame carries a parity bit, sampled on the accept edge
//   PAR_bit     parity bit from the parity calculator
//   TX_OUT      registered serial line, idle high
//   BUSY        registered, high while a frame is in progress
//   TX_DONE     registered one-cycle pulse when the stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic                  DATA_VALID,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_bit,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  TX_DONE
);

    localparam int                CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
    logic                  par_en_q, par_en_d;
    logic                  tx_q,     tx_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic [DATA_WIDTH-1:0] shreg_shifted;

    // Next-state logic. Every output is computed here as the value for the
    // state being entered, so the registered TX_OUT/BUSY change on the same
    // edge as the state. Nothing moves unless TICK is high, which is what
    // stretches each bit over a full TICK period. The bit shown while in
    // DATA is always shreg_q[0]; on a data tick we shift first and present
    // the new LSB, so the line never lags the shift register.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        par_en_d      = par_en_q;
        tx_d          = tx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        shreg_shifted = shreg_q >> 1;

        case (state_q)
            IDLE: begin
                // The accept edge is the last one where the parity calculator
                // sees BUSY low, so it latches parity of this same word.
                if (DATA_VALID && TICK) begin
                    shreg_d  = P_DATA;
                    par_en_d = PAR_EN;
                    cnt_d    = '0;
                    state_d  = START;
                    tx_d     = START_BIT;
                    busy_d   = 1'b1;
                end
            end

            START: begin
                if (TICK) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end

            DATA: begin
                if (TICK) begin
                    shreg_d = shreg_shifted;
                    if (cnt_q == LAST_BIT) begin
                        // Clearing here keeps the counter from wrapping.
                        cnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = PAR_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = STOP_BIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        tx_d  = shreg_shifted[0];
                    end
                end
            end

            PARITY: begin
                if (TICK) begin
                    state_d = STOP;
                    tx_d    = STOP_BIT;
                end
            end

            STOP: begin
                // Always return to IDLE so BUSY drops for at least one
                // cycle and the parity calculator can refresh.
                if (TICK) begin
                    state_d = IDLE;
                    tx_d    = UART_IDLE_LEVEL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = UART_IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset is synchronous and wins over
    // everything, so a frame in progress is abandoned on the next edge
    // with the line returned to idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            par_en_q <= 1'b0;
            tx_q     <= UART_IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            par_en_q <= par_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign TX_OUT  = tx_q;
    assign BUSY    = busy_q;
    assign TX_DONE = done_q;

endmodule
